spdif_tx_feeder: RTL and testbench

Sample scheduler between the mixer output stream and `spdif_tx`. It buffers stereo frames from an upstream valid/ready source and answers the transmitter's per-channel `pop_o` requests with `ack`/`data` pulses. Empty-buffer pops are answered with zero samples and counted as underruns. It also builds the 192-bit consumer channel-status block that drives `spdif_tx.cdata_i`.

---
 rtl/spdif_pkg.sv | 34 +++
 rtl/spdif_frame_fifo.sv | 50 +++++
 rtl/spdif_tx_feeder.sv | 167 ++++++++++++++++
 tb/tb_spdif_tx_feeder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// Shared types and constants for the S/PDIF transmit feeder.
package spdif_pkg;

  // Scheduler state: which half (if any) is being acknowledged this cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK_L = 2'd1,
    ST_ACK_R = 2'd2
  } sched_state_t;

  // Consumer channel-status bit positions.
  localparam int CS_W        = 192;
  localparam int CS_COPY     = 2;
  localparam int CS_FS_LSB   = 24;
  localparam int CS_WLEN_LSB = 32;

  // IEC 60958 sample-rate codes.
  localparam logic [3:0] FS_48K  = 4'b0100;
  localparam logic [3:0] FS_44K1 = 4'b0000;
  localparam logic [3:0] FS_96K  = 4'b0101;

  // Assemble the channel-status block; consumer and PCM bits stay 0.
  function automatic logic [CS_W-1:0] cs_build(input logic       copy,
                                               input logic [3:0] fs,
                                               input logic [3:0] wlen);
    logic [CS_W-1:0] v;
    v                    = {CS_W{1'b0}};
    v[CS_COPY]           = copy;
    v[CS_FS_LSB +: 4]    = fs;
    v[CS_WLEN_LSB +: 4]  = wlen;
    return v;
  endfunction

endpackage

// File: rtl/spdif_frame_fifo.sv
// Synchronous 48-bit stereo frame FIFO; pointers carry an extra wrap bit.
module spdif_frame_fifo #(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [47:0] data_i,
  input  logic        pop_i,
  output logic [47:0] head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] level_o
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [47:0] r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_push;
  logic        w_pop;

  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign level_o = r_wptr - r_rptr;
  assign head_o  = r_mem[r_rptr[AW-1:0]];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  // Frame storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= data_i;
    end
  end

  // Read/write pointer advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= {(AW+1){1'b0}};
      r_rptr <= {(AW+1){1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/spdif_tx_feeder.sv
// Frame buffer and per-channel pop scheduler feeding spdif_tx, plus
// the channel-status block builder.
module spdif_tx_feeder
  import spdif_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int UCNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid_i,
  input  logic [47:0]             s_data_i,
  output logic                    s_ready_o,
  input  logic [1:0]              pop_i,
  output logic [1:0]              ack_o,
  output logic [47:0]             data_o,
  input  logic                    mute_i,
  input  logic                    cfg_load_i,
  input  logic                    cfg_copy_i,
  input  logic [3:0]              cfg_fs_i,
  input  logic [3:0]              cfg_wlen_i,
  output logic [191:0]            cdata_o,
  output logic                    underrun_o,
  output logic [UCNT_W-1:0]       underrun_cnt_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam logic [UCNT_W-1:0] UCNT_ONE = {{(UCNT_W-1){1'b0}}, 1'b1};
  localparam logic [UCNT_W-1:0] UCNT_MAX = {UCNT_W{1'b1}};

  sched_state_t r_state;
  sched_state_t w_next;

  logic [1:0]        r_pop_q;
  logic              r_armed;
  logic              r_pend_l;
  logic              r_pend_r;
  logic [1:0]        r_ack;
  logic [47:0]       r_data;
  logic [23:0]       r_hold;
  logic              r_underrun;
  logic [UCNT_W-1:0] r_ucnt;
  logic [191:0]      r_cdata;

  logic        w_edge_l;
  logic        w_edge_r;
  logic        w_req_l;
  logic        w_req_r;
  logic        w_serve_l;
  logic        w_serve_r;
  logic        w_fifo_pop;
  logic        w_underrun;
  logic        w_full;
  logic        w_empty;
  logic [47:0] w_head;
  logic [23:0] w_left;
  logic [23:0] w_right;

  spdif_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s_valid_i),
    .data_i  (s_data_i),
    .pop_i   (w_fifo_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  // r_armed is low for the first cycle after reset so a pop level that was
  // already high is absorbed into r_pop_q instead of looking like an edge.
  assign w_edge_l = r_armed & pop_i[0] & ~r_pop_q[0];
  assign w_edge_r = r_armed & pop_i[1] & ~r_pop_q[1];
  assign w_req_l  = r_pend_l | w_edge_l;
  assign w_req_r  = r_pend_r | w_edge_r;

  // Underrun (empty FIFO) substitutes a zero frame.
  assign w_left  = w_empty ? 24'd0 : w_head[47:24];
  assign w_right = w_empty ? 24'd0 : w_head[23:0];

  assign s_ready_o      = ~w_full;
  assign ack_o          = r_ack;
  assign data_o         = r_data;
  assign underrun_o     = r_underrun;
  assign underrun_cnt_o = r_ucnt;
  assign cdata_o        = r_cdata;

  // Scheduler state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Scheduler next state; left wins when both requests are outstanding.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_req_l)      w_next = ST_ACK_L;
        else if (w_req_r) w_next = ST_ACK_R;
        else              w_next = ST_IDLE;
      end
      ST_ACK_L: begin
        if (w_req_r) w_next = ST_ACK_R;
        else         w_next = ST_IDLE;
      end
      ST_ACK_R: begin
        if (w_req_l) w_next = ST_ACK_L;
        else         w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Scheduler actions for the state being entered.
  always_comb begin
    w_serve_l  = (w_next == ST_ACK_L);
    w_serve_r  = (w_next == ST_ACK_R);
    w_fifo_pop = w_serve_l & ~w_empty;
    w_underrun = w_serve_l & w_empty;
  end

  // Edge capture, pending requests, acks, delivered data and underrun count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pop_q    <= 2'b00;
      r_armed    <= 1'b0;
      r_pend_l   <= 1'b0;
      r_pend_r   <= 1'b0;
      r_ack      <= 2'b00;
      r_data     <= 48'd0;
      r_hold     <= 24'd0;
      r_underrun <= 1'b0;
      r_ucnt     <= {UCNT_W{1'b0}};
    end else begin
      r_pop_q    <= pop_i;
      r_armed    <= 1'b1;
      r_pend_l   <= w_req_l & ~w_serve_l;
      r_pend_r   <= w_req_r & ~w_serve_r;
      r_ack      <= {w_serve_l, w_serve_r};
      r_underrun <= w_underrun;
      if (w_serve_l) begin
        r_data[47:24] <= mute_i ? 24'd0 : w_left;
        r_hold        <= w_right;
      end else if (w_serve_r) begin
        r_data[23:0]  <= mute_i ? 24'd0 : r_hold;
      end
      if (w_underrun && (r_ucnt != UCNT_MAX)) begin
        r_ucnt <= r_ucnt + UCNT_ONE;
      end
    end
  end

  // Channel-status block, rebuilt only on a configuration load strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cdata <= 192'd0;
    end else if (cfg_load_i) begin
      r_cdata <= cs_build(cfg_copy_i, cfg_fs_i, cfg_wlen_i);
    end
  end

endmodule

// File: tb/tb_spdif_tx_feeder.sv
// Self-checking bench for spdif_tx_feeder against a queue-based model.
module tb_spdif_tx_feeder;

  localparam int DEPTH  = 4;
  localparam int UCNT_W = 3;
  localparam int UMAX   = (1 << UCNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid_i;
  logic [47:0]       s_data_i;
  logic              s_ready_o;
  logic [1:0]        pop_i;
  logic [1:0]        ack_o;
  logic [47:0]       data_o;
  logic              mute_i;
  logic              cfg_load_i;
  logic              cfg_copy_i;
  logic [3:0]        cfg_fs_i;
  logic [3:0]        cfg_wlen_i;
  logic [191:0]      cdata_o;
  logic              underrun_o;
  logic [UCNT_W-1:0] underrun_cnt_o;
  logic [2:0]        level_o;

  spdif_tx_feeder #(.DEPTH(DEPTH), .UCNT_W(UCNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid_i      (s_valid_i),
    .s_data_i       (s_data_i),
    .s_ready_o      (s_ready_o),
    .pop_i          (pop_i),
    .ack_o          (ack_o),
    .data_o         (data_o),
    .mute_i         (mute_i),
    .cfg_load_i     (cfg_load_i),
    .cfg_copy_i     (cfg_copy_i),
    .cfg_fs_i       (cfg_fs_i),
    .cfg_wlen_i     (cfg_wlen_i),
    .cdata_o        (cdata_o),
    .underrun_o     (underrun_o),
    .underrun_cnt_o (underrun_cnt_o),
    .level_o        (level_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [47:0]  q[$];
  logic [23:0]  m_hold;
  logic [23:0]  m_l;
  logic [23:0]  m_r;
  int           m_cnt;
  logic [191:0] m_cs;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_hold = 24'd0;
    m_l    = 24'd0;
    m_r    = 24'd0;
    m_cnt  = 0;
    m_cs   = 192'd0;
  endtask

  // Left request: take a frame or substitute zeros; returns underrun flag.
  task automatic model_left(output bit und);
    logic [47:0] f;
    if (q.size() > 0) begin
      f   = q.pop_front();
      und = 1'b0;
    end else begin
      f     = 48'd0;
      und   = 1'b1;
      m_cnt = (m_cnt == UMAX) ? UMAX : m_cnt + 1;
    end
    m_hold = f[23:0];
    m_l    = mute_i ? 24'd0 : f[47:24];
  endtask

  task automatic model_right();
    m_r = mute_i ? 24'd0 : m_hold;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_ready"}, 192'(s_ready_o), 192'(q.size() < DEPTH));
    chk({tag, "_level"}, 192'(level_o), 192'(q.size()));
    chk({tag, "_ucnt"},  192'(underrun_cnt_o), 192'(m_cnt));
    chk({tag, "_data"},  192'(data_o), 192'({m_l, m_r}));
    chk({tag, "_cdata"}, cdata_o, m_cs);
  endtask

  task automatic push(input logic [47:0] d);
    bit acc;
    acc       = (q.size() < DEPTH);
    s_valid_i = 1'b1;
    s_data_i  = d;
    tick();
    if (acc) q.push_back(d);
    s_valid_i = 1'b0;
    chk("push_ack", 192'(ack_o), 192'(2'b00));
    chk_state("push");
  endtask

  // Left pop pulse, optionally with a concurrent upstream push.
  task automatic pop_left(input bit with_push, input logic [47:0] d);
    bit und;
    bit acc;
    acc       = with_push && (q.size() < DEPTH);
    pop_i     = 2'b01;
    s_valid_i = with_push;
    s_data_i  = d;
    tick();
    model_left(und);
    if (acc) q.push_back(d);
    s_valid_i = 1'b0;
    chk("left_ack", 192'(ack_o), 192'(2'b10));
    chk("left_und", 192'(underrun_o), 192'(und));
    chk_state("left");
    pop_i = 2'b00;
    tick();
    chk("left_ack_off", 192'(ack_o), 192'(2'b00));
    chk("left_und_off", 192'(underrun_o), 192'(1'b0));
  endtask

  task automatic pop_right();
    pop_i = 2'b10;
    tick();
    model_right();
    chk("right_ack", 192'(ack_o), 192'(2'b01));
    chk("right_und", 192'(underrun_o), 192'(1'b0));
    chk_state("right");
    pop_i = 2'b00;
    tick();
    chk("right_ack_off", 192'(ack_o), 192'(2'b00));
  endtask

  // Both requests in the same cycle: left at n+1, right at n+2.
  task automatic pop_both();
    bit und;
    pop_i = 2'b11;
    tick();
    model_left(und);
    chk("both_ack_l", 192'(ack_o), 192'(2'b10));
    chk("both_und", 192'(underrun_o), 192'(und));
    chk_state("both_l");
    tick();
    model_right();
    chk("both_ack_r", 192'(ack_o), 192'(2'b01));
    chk_state("both_r");
    tick();
    chk("both_held", 192'(ack_o), 192'(2'b00));
    pop_i = 2'b00;
    tick();
    chk("both_off", 192'(ack_o), 192'(2'b00));
  endtask

  initial begin
    logic [63:0] rnd;
    int          act;

    rst        = 1'b1;
    s_valid_i  = 1'b0;
    s_data_i   = 48'd0;
    pop_i      = 2'b00;
    mute_i     = 1'b0;
    cfg_load_i = 1'b0;
    cfg_copy_i = 1'b0;
    cfg_fs_i   = 4'd0;
    cfg_wlen_i = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 192'(ack_o), 192'(2'b00));
    chk("rst_und", 192'(underrun_o), 192'(1'b0));
    chk_state("rst");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Normal delivery.
    push({24'h000001, 24'habcdef});
    push({24'h000002, 24'h123456});
    pop_left(1'b0, 48'd0);
    chk("norm_l1", 192'(data_o[47:24]), 192'(24'h000001));
    pop_right();
    chk("norm_r1", 192'(data_o[23:0]), 192'(24'habcdef));
    pop_left(1'b0, 48'd0);
    pop_right();
    chk("norm_r2", 192'(data_o), 192'({24'h000002, 24'h123456}));

    // Underrun on empty FIFO.
    pop_left(1'b0, 48'd0);
    pop_right();
    chk("und_cnt1", 192'(underrun_cnt_o), 192'(1));

    // Simultaneous edges.
    push({24'h0a0a0a, 24'h0b0b0b});
    pop_both();

    // Full FIFO, rejected push, pop frees a slot, push+pop keeps level.
    for (int i = 0; i < DEPTH + 1; i++) push(48'h100000000000 + 48'(i));
    pop_left(1'b0, 48'd0);
    pop_left(1'b1, 48'h777777888888);
    pop_right();

    // Mute consumes the FIFO but delivers zeros; hold stays live.
    mute_i = 1'b1;
    pop_left(1'b0, 48'd0);
    pop_right();
    mute_i = 1'b0;
    pop_right();

    // No bypass: push into empty FIFO while a left request is served.
    while (q.size() > 0) pop_left(1'b0, 48'd0);
    pop_left(1'b1, 48'h0000c0ffee00);
    pop_left(1'b0, 48'd0);

    // Channel status: inputs alone do nothing, load latches them.
    cfg_copy_i = 1'b1;
    cfg_fs_i   = 4'b0100;
    cfg_wlen_i = 4'b1011;
    tick();
    chk_state("cs_noload");
    cfg_load_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    m_cs       = 192'd0;
    m_cs[2]    = 1'b1;
    m_cs[27:24] = 4'h4;
    m_cs[35:32] = 4'hB;
    cfg_copy_i = 1'b0;
    cfg_fs_i   = 4'b0101;
    cfg_wlen_i = 4'b0010;
    tick();
    chk_state("cs_load");

    // Randomized traffic, including counter saturation.
    for (int i = 0; i < 300; i++) begin
      rnd    = {$urandom(), $urandom()};
      mute_i = ($urandom_range(0, 7) == 0);
      act    = $urandom_range(0, 4);
      case (act)
        0: push(rnd[47:0]);
        1: pop_left(1'b0, 48'd0);
        2: pop_right();
        3: pop_both();
        default: pop_left(1'b1, rnd[47:0]);
      endcase
    end
    mute_i = 1'b0;

    // Reset mid-operation with frames queued and pop[0] held high.
    while (q.size() < 3) push(48'h123123456456);
    while (q.size() > 3) pop_left(1'b0, 48'd0);
    pop_i = 2'b01;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_ack", 192'(ack_o), 192'(2'b00));
    chk("mid_rst_und", 192'(underrun_o), 192'(1'b0));
    chk_state("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_noack", 192'(ack_o), 192'(2'b00));
    end
    chk_state("post_rst");
    pop_i = 2'b00;
    tick();
    push({24'h00abcd, 24'h00dcba});
    pop_left(1'b0, 48'd0);
    pop_right();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
